// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared encodings and decode helpers for the muldiv sequencer.
//            This package holds the funct3 opcodes, the FSM state codes and
//            the per-op signedness and result-half selectors.
// Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    typedef logic [2:0] op_t;

    // funct3 encodings of the M-extension ops
    localparam op_t c_op_mul    = 3'b000;
    localparam op_t c_op_mulh   = 3'b001;
    localparam op_t c_op_mulhsu = 3'b010;
    localparam op_t c_op_mulhu  = 3'b011;
    localparam op_t c_op_div    = 3'b100;
    localparam op_t c_op_divu   = 3'b101;
    localparam op_t c_op_rem    = 3'b110;
    localparam op_t c_op_remu   = 3'b111;

    // Sequencer states
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    // All divide and remainder ops have funct3[2] set
    function automatic logic is_div(input op_t op);
        return op[2];
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic is_signed_0(input op_t op);
        return (op == c_op_mulh) || (op == c_op_mulhsu) ||
               (op == c_op_div)  || (op == c_op_rem);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic is_signed_1(input op_t op);
        return (op == c_op_mulh) || (op == c_op_div) || (op == c_op_rem);
    endfunction

    // Multiplies other than MUL return the upper half of the product
    function automatic logic sel_high(input op_t op);
        return !op[2] && (op[1:0] != 2'b00);
    endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Brief    : Request/response bundle between the execute stage and the
//            muldiv sequencer. The master is the pipeline and the slave is
//            the sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH       = 32,
    parameter int RF_ADD_SIZE = 5
);
    logic                   i_start;
    logic                   i_flush;
    logic [2:0]             i_op;
    logic [WIDTH-1:0]       i_op_0;
    logic [WIDTH-1:0]       i_op_1;
    logic [RF_ADD_SIZE-1:0] i_dst;
    logic                   o_busy;
    logic                   o_stall;
    logic                   o_done;
    logic [WIDTH-1:0]       o_result;
    logic [RF_ADD_SIZE-1:0] o_dst;

    modport master (
        output i_start, i_flush, i_op, i_op_0, i_op_1, i_dst,
        input  o_busy, o_stall, o_done, o_result, o_dst
    );

    modport slave (
        input  i_start, i_flush, i_op, i_op_0, i_op_1, i_dst,
        output o_busy, o_stall, o_done, o_result, o_dst
    );
endinterface : muldiv_if
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Brief    : One combinational iteration of the shared datapath.
//            Multiply: shift-add on the multiplier LSB, {hi,lo} >> 1.
//            Divide  : restoring trial-subtract on the {rem,quot} register.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  wire logic                 i_div,
    input  wire logic [2*WIDTH-1:0]   i_acc,
    input  wire logic [WIDTH-1:0]     i_opb,
    output logic      [2*WIDTH-1:0]   o_acc
);
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift_hi;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    assign w_hi = i_acc[2*WIDTH-1:WIDTH];
    assign w_lo = i_acc[WIDTH-1:0];

    // Multiply partial sum keeps the carry so it can shift into the top bit
    assign w_sum = {1'b0, w_hi} + {1'b0, i_opb};

    // Remainder after shifting in the next dividend bit; it can need WIDTH+1
    // bits, but whenever it is >= divisor the difference fits in WIDTH bits
    assign w_shift_hi = {w_hi, w_lo[WIDTH-1]};
    assign w_ge       = (w_shift_hi >= {1'b0, i_opb});
    assign w_diff     = w_shift_hi[WIDTH-1:0] - i_opb;

    // Select the next accumulator value for the active operation
    always_comb begin
        o_acc = i_acc;
        if (i_div) begin
            if (w_ge) begin
                o_acc = {w_diff, w_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_acc = {w_shift_hi[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (w_lo[0]) begin
                o_acc = {w_sum, w_lo[WIDTH-1:1]};
            end else begin
                o_acc = {1'b0, w_hi, w_lo[WIDTH-1:1]};
            end
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Iterative RISC-V M-extension sequencer. Works on operand
//            magnitudes for WIDTH cycles, then applies sign correction and
//            the div-by-zero and overflow overrides in FIX. The result is
//            presented with a one-cycle done pulse in DONE.
//            Optional macro MULDIV_EARLY_OUT_EN: zero-operand ops skip CALC.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int RF_ADD_SIZE = 5
) (
    input  wire logic i_clk,
    input  wire logic i_rst,
    muldiv_if.slave   bus
);
    localparam int                 c_cnt_w   = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [WIDTH-1:0]   c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]             r_state;
    logic [c_cnt_w-1:0]     r_count;
    logic [2:0]             r_op;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_opb;
    logic [WIDTH-1:0]       r_op0;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_dz;
    logic                   r_ovf;
    logic [RF_ADD_SIZE-1:0] r_dst_pend;
    logic [RF_ADD_SIZE-1:0] r_dst;
    logic [WIDTH-1:0]       r_result;

    logic                   w_idle_or_done;
    logic                   w_busy;
    logic                   w_accept;
    logic                   w_s0;
    logic                   w_s1;
    logic [WIDTH-1:0]       w_abs0;
    logic [WIDTH-1:0]       w_abs1;
    logic                   w_dz;
    logic                   w_ovf;
    logic                   w_early;
    logic [2*WIDTH-1:0]     w_step_acc;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_quot;
    logic [WIDTH-1:0]       w_rem;
    logic [WIDTH-1:0]       w_fix;

    assign w_idle_or_done = (r_state == c_st_idle) || (r_state == c_st_done);
    assign w_busy         = (r_state == c_st_calc) || (r_state == c_st_fix);
    assign w_accept       = bus.i_start & ~bus.i_flush & w_idle_or_done;

    // Operand signs and magnitudes; the most-negative value maps onto its
    // own unsigned magnitude, which is exactly what the datapath needs
    assign w_s0   = is_signed_0(bus.i_op) & bus.i_op_0[WIDTH-1];
    assign w_s1   = is_signed_1(bus.i_op) & bus.i_op_1[WIDTH-1];
    assign w_abs0 = w_s0 ? -bus.i_op_0 : bus.i_op_0;
    assign w_abs1 = w_s1 ? -bus.i_op_1 : bus.i_op_1;
    assign w_dz   = (bus.i_op_1 == '0);
    assign w_ovf  = is_div(bus.i_op) & is_signed_1(bus.i_op) &
                    (bus.i_op_0 == c_min_neg) & (&bus.i_op_1);

`ifdef MULDIV_EARLY_OUT_EN
    // A zero divisor, or any zero multiply operand, has a known answer
    assign w_early = w_dz | (~is_div(bus.i_op) & (bus.i_op_0 == '0));
`else
    assign w_early = 1'b0;
`endif

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_div (is_div(r_op)),
        .i_acc (r_acc),
        .i_opb (r_opb),
        .o_acc (w_step_acc)
    );

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    // Final result selection, with the architectural special cases on top
    always_comb begin
        w_fix = '0;
        if (!is_div(r_op)) begin
            w_fix = sel_high(r_op) ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
        end else if (r_dz) begin
            w_fix = r_op[1] ? r_op0 : '1;
        end else if (r_ovf) begin
            w_fix = r_op[1] ? '0 : c_min_neg;
        end else begin
            w_fix = r_op[1] ? w_rem : w_quot;
        end
    end

    // Request capture, iteration and result commit. The tag is committed to
    // o_dst together with the result so a flushed op leaves both untouched.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= c_st_idle;
            r_count    <= '0;
            r_op       <= '0;
            r_acc      <= '0;
            r_opb      <= '0;
            r_op0      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
            r_dst_pend <= '0;
            r_dst      <= '0;
            r_result   <= '0;
        end else if (bus.i_flush) begin
            r_state <= c_st_idle;
            r_count <= '0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (w_accept) begin
                        r_op       <= bus.i_op;
                        r_dst_pend <= bus.i_dst;
                        r_op0      <= bus.i_op_0;
                        r_acc      <= w_early ? '0 : {{WIDTH{1'b0}}, w_abs0};
                        r_opb      <= w_abs1;
                        r_neg_q    <= w_s0 ^ w_s1;
                        r_neg_r    <= w_s0;
                        r_dz       <= w_dz;
                        r_ovf      <= w_ovf;
                        r_count    <= '0;
                        r_state    <= w_early ? c_st_fix : c_st_calc;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end
                c_st_calc: begin
                    r_acc   <= w_step_acc;
                    r_count <= r_count + c_cnt_one;
                    if (r_count == c_last) begin
                        r_state <= c_st_fix;
                    end
                end
                c_st_fix: begin
                    r_result <= w_fix;
                    r_dst    <= r_dst_pend;
                    r_state  <= c_st_done;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.o_busy   = w_busy;
    assign bus.o_stall  = w_accept | w_busy;
    assign bus.o_done   = (r_state == c_st_done);
    assign bus.o_result = r_result;
    assign bus.o_dst    = r_dst;

endmodule : muldiv_seq
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_seq
// Brief    : Scoreboard bench for muldiv_seq: directed and random ops
//            against an arithmetic reference model, plus flush, reset and
//            back-to-back timing scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int RA  = 5;
    localparam int LAT = W + 2;

    typedef struct {
        logic [W-1:0]  res;
        logic [RA-1:0] dst;
        int            acc_cyc;
        int            lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    int            cyc = 0;
    int            tests = 0;
    int            fails = 0;
    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [W-1:0]  last_res = '0;
    logic [RA-1:0] last_dst = '0;

    muldiv_if #(.WIDTH(W), .RF_ADD_SIZE(RA)) bus();

    muldiv_seq #(
        .WIDTH       (W),
        .RF_ADD_SIZE (RA)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on extended operands
    function automatic logic [W-1:0] ref_model(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        longint      sa;
        longint      sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ea = (op == c_op_mulh || op == c_op_mulhsu) ? {{32{a[W-1]}}, a} : {32'b0, a};
        eb = (op == c_op_mulh) ? {{32{b[W-1]}}, b} : {32'b0, b};
        p  = '0;
        case (op)
            c_op_mul:    p = ea * eb;
            c_op_mulh,
            c_op_mulhsu,
            c_op_mulhu:  p = (ea * eb) >> 32;
            c_op_div:    p = (b == 0) ? 64'hFFFF_FFFF :
                             (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 64'h8000_0000 :
                             64'(sa / sb);
            c_op_divu:   p = (b == 0) ? 64'hFFFF_FFFF : {32'b0, a / b};
            c_op_rem:    p = (b == 0) ? {32'b0, a} :
                             (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 64'd0 :
                             64'(sa % sb);
            default:     p = (b == 0) ? {32'b0, a} : {32'b0, a % b};
        endcase
        return p[W-1:0];
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (b == 0 || (!op[2] && a == 0)) return 2;
`endif
        return LAT;
    endfunction

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 50));
            default: return 32'($urandom);
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (!rst && bus.o_done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(bus.o_done), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("result", 64'(bus.o_result), 64'(mon_e.res));
                chk("dst", 64'(bus.o_dst), 64'(mon_e.dst));
                chk("latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
                last_res = mon_e.res;
                last_dst = mon_e.dst;
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.o_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("idle_timeout", 64'(bus.o_busy), 64'd0);
    endtask

    // Drive one request at a negedge where the sequencer is not busy
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [RA-1:0] d, input bit push, output logic stall0);
        exp_t e;
        bus.i_start = 1'b1;
        bus.i_op    = op;
        bus.i_op_0  = a;
        bus.i_op_1  = b;
        bus.i_dst   = d;
        if (push) begin
            e.res     = ref_model(op, a, b);
            e.dst     = d;
            e.acc_cyc = cyc;
            e.lat     = exp_lat(op, a, b);
            exp_q.push_back(e);
        end
        #1 stall0 = bus.o_stall;
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_op    = 3'($urandom);
        bus.i_op_0  = 32'($urandom);
        bus.i_op_1  = 32'($urandom);
        bus.i_dst   = 5'($urandom);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [RA-1:0] d);
        logic s;
        wait_idle(200);
        issue(op, a, b, d, 1'b1, s);
    endtask

    initial begin
        logic       s0;
        logic       stall_ok;
        logic [2:0] rop;
        int         n;

        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_op    = '0;
        bus.i_op_0  = '0;
        bus.i_op_1  = '0;
        bus.i_dst   = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        chk("rst_result", 64'(bus.o_result), 64'd0);
        chk("rst_dst", 64'(bus.o_dst), 64'd0);
        chk("rst_stall", 64'(bus.o_stall), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // MUL 7 * -3 with the stall window checked cycle by cycle
        issue(c_op_mul, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1, s0);
        stall_ok = s0;
        repeat (33) begin
            if (!bus.o_stall) stall_ok = 1'b0;
            @(negedge clk);
        end
        chk("mul_stall_window", 64'(stall_ok), 64'd1);
        chk("mul_done_cycle", 64'(bus.o_done), 64'd1);
        chk("mul_stall_low_in_done", 64'(bus.o_stall), 64'd0);

        // Directed set; each one is issued in the DONE cycle of the previous
        run_op(c_op_mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        run_op(c_op_mulh,   32'h8000_0000, 32'h8000_0000, 5'd5);
        run_op(c_op_mulhsu, 32'hFFFF_FFFF, 32'd2,         5'd6);
        run_op(c_op_div,    32'hFFFF_FFF9, 32'd2,         5'd7);
        run_op(c_op_rem,    32'hFFFF_FFF9, 32'd2,         5'd8);
        run_op(c_op_divu,   32'd100,       32'd7,         5'd9);
        run_op(c_op_remu,   32'd100,       32'd7,         5'd10);
        run_op(c_op_divu,   32'd5,         32'd0,         5'd11);
        run_op(c_op_rem,    32'd5,         32'd0,         5'd12);
        run_op(c_op_div,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
        run_op(c_op_rem,    32'h8000_0000, 32'hFFFF_FFFF, 5'd14);
        run_op(c_op_divu,   32'd9,         32'd0,         5'd15);
        run_op(c_op_mul,    32'd0,         32'd1234,      5'd16);

        // Flush at CALC count 10: no done, outputs keep the previous result
        wait_idle(200);
        issue(c_op_mulhu, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20, 1'b0, s0);
        repeat (10) @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        chk("flush_busy", 64'(bus.o_busy), 64'd0);
        chk("flush_stall", 64'(bus.o_stall), 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_result_kept", 64'(bus.o_result), 64'(last_res));
        chk("flush_dst_kept", 64'(bus.o_dst), 64'(last_dst));

        // Start together with flush in IDLE is not accepted
        bus.i_start = 1'b1;
        bus.i_flush = 1'b1;
        bus.i_op    = c_op_divu;
        bus.i_op_0  = 32'd50;
        bus.i_op_1  = 32'd5;
        #1 chk("start_flush_stall", 64'(bus.o_stall), 64'd0);
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        chk("start_flush_busy", 64'(bus.o_busy), 64'd0);
        repeat (40) @(negedge clk);

        // Reset in the middle of CALC returns everything to zero at once
        issue(c_op_div, 32'd1000, 32'd3, 5'd21, 1'b0, s0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(bus.o_busy), 64'd0);
        chk("midrst_done", 64'(bus.o_done), 64'd0);
        chk("midrst_result", 64'(bus.o_result), 64'd0);
        chk("midrst_dst", 64'(bus.o_dst), 64'd0);
        chk("midrst_stall", 64'(bus.o_stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
        last_dst = '0;
        @(negedge clk);

        // Randomized ops with occasional idle gaps
        for (int i = 0; i < 150; i++) begin
            wait_idle(200);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rop = 3'($urandom_range(0, 7));
            run_op(rop, rnd_val(), rnd_val(), 5'($urandom));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_muldiv_seq
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative M-extension sequencer beside the execute stage. Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request per handshake and runs a shared shift-add / restoring-subtract datapath for WIDTH cycles. Holds the pipeline stall while it runs. Returns the result with its destination tag for the IE→IM register.

Parameters:
WIDTH, 32, operand/result width; power of two, at least 8
RF_ADD_SIZE, 5, register-file address width of the destination tag

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous reset, active-high
i_start  in  1  request valid, sampled in IDLE or DONE
i_flush  in  1  abort in-flight op (branch/jump redirect)
i_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
i_op_0  in  WIDTH  rs1 after forwarding
i_op_1  in  WIDTH  rs2 after forwarding
i_dst  in  RF_ADD_SIZE  destination register tag
o_busy  out  1  state is CALC or FIX
o_stall  out  1  combinational: (i_start & ~i_flush & state∈{IDLE,DONE}) | o_busy
o_done  out  1  result valid, one-cycle pulse
o_result  out  WIDTH  registered result, held until next accept
o_dst  out  RF_ADD_SIZE  tag latched at accept

Behaviour:
- Reset (async, i_rst=1): state IDLE, count 0, o_busy 0, o_done 0, o_result 0, o_dst 0, internal regs 0.
- States: IDLE, CALC, FIX, DONE.
- Accept: i_start=1 & i_flush=0 in IDLE or DONE.
  - Latch op and tag.
  - Latch |op_0| and |op_1| per signedness: MULH/DIV/REM both signed; MULHSU op_0 only.
  - Latch the result sign bit(s) and special flags: div-by-zero (op_1==0) and signed overflow.
  - count←0, next state CALC.
- i_start in CALC/FIX is ignored (stall is already high).
- CALC: one iteration per cycle.
  - Multiply: 2·WIDTH-bit accumulator, shift-add on the LSB of the multiplier.
  - Divide: restoring step on a {rem,quot} shift register.
  - count increments each cycle. At count==WIDTH-1, next state FIX.
  - Accept in cycle N gives CALC for N+1..N+WIDTH.
- FIX (cycle N+WIDTH+1): apply sign correction (two's-complement negate when the flag is set), then select:
  - MUL: low half.
  - MULH/MULHSU/MULHU: high half.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder, signed with the dividend's sign.
  - The result is written to o_result. Next state DONE.
- Special-case overrides, applied in FIX:
  - div-by-zero: DIV/DIVU → all ones; REM/REMU → original op_0.
  - overflow (op_0 = 1000…0 and op_1 = all ones, signed): DIV → 1000…0; REM → 0.
- DONE (cycle N+WIDTH+2): o_done=1 for exactly one cycle; o_stall low unless a new accept happens. Next state is CALC on accept, else IDLE.
- Total latency: accept to o_done = WIDTH+2 cycles (34 at default).
- Flush:
  - i_flush=1 in any state forces IDLE next cycle. No o_done. o_result and o_dst keep their old value.
  - Flush in the same cycle as start: flush wins, the request is not accepted.
  - Flush in DONE: the o_done pulse in that cycle still stands; the IE→IM register is responsible for squashing it.
- Reset mid-operation: immediate return to reset values, no done.
- Arithmetic is modulo 2^WIDTH. Absolute value of the most-negative number is taken as an unsigned WIDTH-bit value.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: at accept, if op_1==0 (any op), or op_0==0 for a multiply, skip CALC and go straight to FIX.
  - FIX produces 0 for multiplies and the div-by-zero override for divides.
  - o_done arrives at N+2.
- Undefined: every op takes the full WIDTH+2 cycles.
- Results are identical either way; only latency differs.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 op encodings.
  - State encoding.
  - Helpers is_div(op), is_signed_0(op), is_signed_1(op), sel_high(op).
- One sub-module, muldiv_step: the combinational single-iteration unit (add-or-pass for multiply, trial-subtract for divide), instantiated once. The FSM, counter and registers stay in muldiv_seq.

Test Plan:
- MUL 7 × 0xFFFFFFFD (-3), accepted at cycle 0 → o_stall high cycles 0–33, o_done at cycle 34, o_result 0xFFFFFFEB; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Flush at CALC count 10 → IDLE next cycle, o_busy 0, no o_done, o_result unchanged; start+flush together in IDLE → not accepted, o_stall 0.
- Back-to-back: new start during DONE → o_done pulse, then second o_done exactly 34 cycles later; i_rst asserted mid-CALC → all outputs 0 immediately. With MULDIV_EARLY_OUT_EN: DIVU x/0 → o_done at cycle 2.
